trap_uop_gen: RTL and testbench
===============================

# trap_uop_gen

Generates the single-cycle trap micro-op stream consumed by the trap handler. It sits between ROB commit and the trap handler. Each cycle it selects at most one of three events: a committed uop needing trap/flush service, a commit-hang timeout, or a not-executed (NX) stall-PC debug lookup. It holds commit stalled until the resulting flush returns.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: consecutive non-retiring cycles with a valid ROB head before a timeout uop is issued; power of two, ≥ 4.
- SQN_W, 7: width of sqN/storeSqN/loadSqN.
- FID_W, 4: fetchID width.
- FOFF_W, 3: fetchOffs width.

Ports. Reset is asynchronous, active-high; one clock.
- clk  in  1  clock
- rst  in  1  async active-high reset
- IN_commitTrap  in  1  committing uop requires trap-handler service
- IN_commitRetire  in  1  at least one uop retired this cycle
- IN_flags  in  4  flags of the committing uop (codebase FLAGS_* encoding)
- IN_rd  in  5  rd field of the committing uop (trap subcode for FLAGS_TRAP)
- IN_sqN, IN_storeSqN, IN_loadSqN  in  SQN_W each  sequence numbers of the committing uop
- IN_fetchID  in  FID_W; IN_fetchOffs  in  FOFF_W; IN_compressed  in  1  location of the committing uop
- IN_headValid  in  1  ROB head holds a valid uncommitted uop
- IN_head*  in  same widths as the commit fields  sqN/storeSqN/loadSqN/fetchID/fetchOffs/compressed of the ROB head
- IN_branchTaken  in  1  flush observed from the trap handler or any branch source
- IN_disableTimeout  in  1  suppresses timeout and debug-lookup generation
- OUT_valid, OUT_timeout  out  1 each
- OUT_flags  out  4; OUT_rd  out  5; OUT_sqN, OUT_storeSqN, OUT_loadSqN  out  SQN_W each
- OUT_fetchID  out  FID_W; OUT_fetchOffs  out  FOFF_W; OUT_compressed  out  1
- OUT_stall  out  1  blocks ROB commit

## Operation
- States: IDLE and WAIT_FLUSH. The hang counter `cnt` has width $clog2(TIMEOUT_CYCLES).
- All outputs are registered. Reset values: OUT_valid=0, OUT_timeout=0, OUT_stall=0, all data fields 0, state=IDLE, cnt=0.
- IDLE priority per cycle:
  1. IN_commitTrap: issue the commit uop, with timeout=0 and all fields copied from IN_*. Go to WAIT_FLUSH. Clear cnt.
  2. Timeout condition (IN_headValid && !IN_commitRetire && !IN_branchTaken && !IN_disableTimeout && cnt==TIMEOUT_CYCLES-1): issue a uop with timeout=1, flags=FLAGS_NX, rd=0, and all other fields taken from IN_head*. Go to WAIT_FLUSH. Clear cnt.
  3. Debug condition (same qualifiers as timeout, but cnt==TIMEOUT_CYCLES/2-1): issue a uop with timeout=0, flags=FLAGS_NX, and fields from IN_head*. Stay in IDLE. cnt increments.
  4. Otherwise no uop is issued.
- Counter rule in IDLE:
  - Increment when IN_headValid && !IN_commitRetire && !IN_branchTaken && !IN_commitTrap.
  - Otherwise clear to 0.
  - While IN_disableTimeout=1, cnt still counts but saturates at TIMEOUT_CYCLES-1; it never wraps.
- WAIT_FLUSH:
  - OUT_stall=1. IN_commitTrap is ignored; upstream holds it because stall is asserted. cnt is held at 0.
  - On IN_branchTaken, go to IDLE and deassert OUT_stall the following cycle.
- IN_branchTaken in IDLE only clears cnt. A commit trap in the same cycle is still accepted.
- The issued uop is dropped (not queued) if no downstream flush follows. The block stays in WAIT_FLUSH until a flush arrives; this is the intended behaviour.
- When OUT_valid=0, the data fields hold their last values.
- Asynchronous reset at any time returns every output and all state to the reset values immediately, including mid-WAIT_FLUSH.

## Timing
- Commit trap sampled at edge N: OUT_valid=1 and OUT_stall=1 in cycle N+1; OUT_valid=0 in N+2.
- Stall starting at cycle k (first qualifying cycle, cnt=0): debug uop is valid in cycle k+TIMEOUT_CYCLES/2, timeout uop is valid in cycle k+TIMEOUT_CYCLES.
- IN_branchTaken sampled in WAIT_FLUSH at edge M: OUT_stall=0 from M+1. A new commit trap can be accepted at edge M+1, giving OUT_valid in M+2.
- Maximum throughput is one trap uop per flush round trip. OUT_valid is never high for two consecutive cycles, except for a debug uop followed by a commit trap.

## Test plan
- Reset, then IN_commitTrap=1, flags=FLAGS_TRAP, rd=5'd11, sqN=7'h12 -> next cycle OUT_valid=1, OUT_timeout=0, OUT_rd=11, OUT_sqN=0x12, OUT_stall=1. OUT_stall stays 1 until IN_branchTaken, then is 0 the following cycle.
- TIMEOUT_CYCLES=16, IN_headValid=1, no retire from cycle 0, IN_headSqN=7'h05 -> cycle 8: OUT_valid=1, OUT_flags=FLAGS_NX, OUT_timeout=0. Cycle 16: OUT_valid=1, OUT_timeout=1, OUT_sqN=0x05, OUT_stall=1.
- Same stall with an IN_commitRetire pulse at cycle 10 -> no timeout at cycle 16. Timeout occurs at cycle 27 instead.
- In WAIT_FLUSH, apply IN_commitTrap=1 for 3 cycles with no flush -> no OUT_valid pulses and OUT_stall stays 1.
- IN_commitTrap and the timeout condition in the same cycle -> a single uop is issued with OUT_timeout=0 and commit fields.
- Assert rst asynchronously mid-clock while in WAIT_FLUSH -> OUT_stall=0 and OUT_valid=0 without waiting for a clock edge. After release, state is IDLE and cnt=0.

Source files
------------

// File: rtl/trap_uop_gen.sv
// Trap micro-op generator between ROB commit and the trap handler: commit traps, hang timeouts, NX debug lookups.
// Latency: one cycle from sampled event to OUT_valid; all outputs registered.
// Backpressure: OUT_stall holds ROB commit from issue of a redirecting uop until a flush (IN_branchTaken) returns.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   IN_commitTrap/Retire          committing uop needs trap service / some uop retired this cycle
//   IN_flags, IN_rd, IN_*SqN      fields of the committing uop
//   IN_fetchID/Offs, IN_compressed location of the committing uop
//   IN_headValid, IN_head*        ROB head valid and its sequence/location fields
//   IN_branchTaken                any flush observed
//   IN_disableTimeout             suppresses timeout and debug uops (counter still runs, saturating)
//   OUT_valid, OUT_timeout, OUT_* issued uop (fields hold when OUT_valid=0)
//   OUT_stall                     blocks ROB commit while waiting for the flush
module trap_uop_gen #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int SQN_W          = 7,
   parameter int FID_W          = 4,
   parameter int FOFF_W         = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IN_commitTrap,
   input  logic              IN_commitRetire,
   input  logic [3:0]        IN_flags,
   input  logic [4:0]        IN_rd,
   input  logic [SQN_W-1:0]  IN_sqN,
   input  logic [SQN_W-1:0]  IN_storeSqN,
   input  logic [SQN_W-1:0]  IN_loadSqN,
   input  logic [FID_W-1:0]  IN_fetchID,
   input  logic [FOFF_W-1:0] IN_fetchOffs,
   input  logic              IN_compressed,
   input  logic              IN_headValid,
   input  logic [SQN_W-1:0]  IN_headSqN,
   input  logic [SQN_W-1:0]  IN_headStoreSqN,
   input  logic [SQN_W-1:0]  IN_headLoadSqN,
   input  logic [FID_W-1:0]  IN_headFetchID,
   input  logic [FOFF_W-1:0] IN_headFetchOffs,
   input  logic              IN_headCompressed,
   input  logic              IN_branchTaken,
   input  logic              IN_disableTimeout,
   output logic              OUT_valid,
   output logic              OUT_timeout,
   output logic [3:0]        OUT_flags,
   output logic [4:0]        OUT_rd,
   output logic [SQN_W-1:0]  OUT_sqN,
   output logic [SQN_W-1:0]  OUT_storeSqN,
   output logic [SQN_W-1:0]  OUT_loadSqN,
   output logic [FID_W-1:0]  OUT_fetchID,
   output logic [FOFF_W-1:0] OUT_fetchOffs,
   output logic              OUT_compressed,
   output logic              OUT_stall
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_DBG  = CNT_W'(TIMEOUT_CYCLES / 2 - 1);
   localparam logic [3:0]       FLAGS_NX = 4'hF;

   typedef enum logic {IDLE, WAIT_FLUSH} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                valid_q, valid_d;
   logic                timeout_q, timeout_d;
   logic                stall_q, stall_d;
   logic [3:0]          flags_q, flags_d;
   logic [4:0]          rd_q, rd_d;
   logic [SQN_W-1:0]    sqn_q, sqn_d;
   logic [SQN_W-1:0]    ssqn_q, ssqn_d;
   logic [SQN_W-1:0]    lsqn_q, lsqn_d;
   logic [FID_W-1:0]    fid_q, fid_d;
   logic [FOFF_W-1:0]   foffs_q, foffs_d;
   logic                comp_q, comp_d;

   // Head is stuck this cycle; "armed" additionally allows a timeout/debug uop.
   logic stuck, armed;
   assign stuck = IN_headValid && !IN_commitRetire && !IN_branchTaken;
   assign armed = stuck && !IN_disableTimeout;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      flags_d   = flags_q;
      rd_d      = rd_q;
      sqn_d     = sqn_q;
      ssqn_d    = ssqn_q;
      lsqn_d    = lsqn_q;
      fid_d     = fid_q;
      foffs_d   = foffs_q;
      comp_d    = comp_q;
      case (state_q)
         IDLE: begin
            if (IN_commitTrap) begin
               valid_d = 1'b1;
               flags_d = IN_flags;
               rd_d    = IN_rd;
               sqn_d   = IN_sqN;
               ssqn_d  = IN_storeSqN;
               lsqn_d  = IN_loadSqN;
               fid_d   = IN_fetchID;
               foffs_d = IN_fetchOffs;
               comp_d  = IN_compressed;
               state_d = WAIT_FLUSH;
               cnt_d   = '0;
            end else begin
               // Timeout and debug uops both describe the ROB head.
               if (armed && (cnt_q == CNT_MAX || cnt_q == CNT_DBG)) begin
                  valid_d   = 1'b1;
                  timeout_d = (cnt_q == CNT_MAX);
                  flags_d   = FLAGS_NX;
                  rd_d      = '0;
                  sqn_d     = IN_headSqN;
                  ssqn_d    = IN_headStoreSqN;
                  lsqn_d    = IN_headLoadSqN;
                  fid_d     = IN_headFetchID;
                  foffs_d   = IN_headFetchOffs;
                  comp_d    = IN_headCompressed;
               end
               if (armed && cnt_q == CNT_MAX) begin
                  state_d = WAIT_FLUSH;
                  cnt_d   = '0;
               end else if (stuck) begin
                  // Only reachable at CNT_MAX with timeouts disabled: saturate, never wrap.
                  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
         end
         WAIT_FLUSH: begin
            cnt_d = '0;
            if (IN_branchTaken) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      stall_d = (state_d == WAIT_FLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         stall_q   <= 1'b0;
         flags_q   <= '0;
         rd_q      <= '0;
         sqn_q     <= '0;
         ssqn_q    <= '0;
         lsqn_q    <= '0;
         fid_q     <= '0;
         foffs_q   <= '0;
         comp_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flags_q   <= flags_d;
         rd_q      <= rd_d;
         sqn_q     <= sqn_d;
         ssqn_q    <= ssqn_d;
         lsqn_q    <= lsqn_d;
         fid_q     <= fid_d;
         foffs_q   <= foffs_d;
         comp_q    <= comp_d;
      end
   end

   assign OUT_valid      = valid_q;
   assign OUT_timeout    = timeout_q;
   assign OUT_stall      = stall_q;
   assign OUT_flags      = flags_q;
   assign OUT_rd         = rd_q;
   assign OUT_sqN        = sqn_q;
   assign OUT_storeSqN   = ssqn_q;
   assign OUT_loadSqN    = lsqn_q;
   assign OUT_fetchID    = fid_q;
   assign OUT_fetchOffs  = foffs_q;
   assign OUT_compressed = comp_q;

endmodule

// File: tb/tb_trap_uop_gen.sv
module tb_trap_uop_gen;

   localparam int T = 16;
   localparam logic [3:0] FLAGS_TRAP = 4'h2;
   localparam logic [3:0] FLAGS_NX   = 4'hF;

   logic clk = 1'b0;
   logic rst;
   logic IN_commitTrap, IN_commitRetire, IN_compressed, IN_headValid, IN_headCompressed;
   logic IN_branchTaken, IN_disableTimeout;
   logic [3:0] IN_flags, IN_fetchID, IN_headFetchID;
   logic [4:0] IN_rd;
   logic [6:0] IN_sqN, IN_storeSqN, IN_loadSqN, IN_headSqN, IN_headStoreSqN, IN_headLoadSqN;
   logic [2:0] IN_fetchOffs, IN_headFetchOffs;
   logic OUT_valid, OUT_timeout, OUT_compressed, OUT_stall;
   logic [3:0] OUT_flags, OUT_fetchID;
   logic [4:0] OUT_rd;
   logic [6:0] OUT_sqN, OUT_storeSqN, OUT_loadSqN;
   logic [2:0] OUT_fetchOffs;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   trap_uop_gen #(.TIMEOUT_CYCLES(T), .SQN_W(7), .FID_W(4), .FOFF_W(3)) dut (
      .clk(clk), .rst(rst),
      .IN_commitTrap(IN_commitTrap), .IN_commitRetire(IN_commitRetire),
      .IN_flags(IN_flags), .IN_rd(IN_rd),
      .IN_sqN(IN_sqN), .IN_storeSqN(IN_storeSqN), .IN_loadSqN(IN_loadSqN),
      .IN_fetchID(IN_fetchID), .IN_fetchOffs(IN_fetchOffs), .IN_compressed(IN_compressed),
      .IN_headValid(IN_headValid),
      .IN_headSqN(IN_headSqN), .IN_headStoreSqN(IN_headStoreSqN), .IN_headLoadSqN(IN_headLoadSqN),
      .IN_headFetchID(IN_headFetchID), .IN_headFetchOffs(IN_headFetchOffs),
      .IN_headCompressed(IN_headCompressed),
      .IN_branchTaken(IN_branchTaken), .IN_disableTimeout(IN_disableTimeout),
      .OUT_valid(OUT_valid), .OUT_timeout(OUT_timeout), .OUT_flags(OUT_flags), .OUT_rd(OUT_rd),
      .OUT_sqN(OUT_sqN), .OUT_storeSqN(OUT_storeSqN), .OUT_loadSqN(OUT_loadSqN),
      .OUT_fetchID(OUT_fetchID), .OUT_fetchOffs(OUT_fetchOffs), .OUT_compressed(OUT_compressed),
      .OUT_stall(OUT_stall)
   );

   // Reference model: "waiting for flush" flag plus length of the current unbroken head stall.
   bit         m_wait;
   int         m_run;
   logic       m_valid, m_timeout, m_stall, m_comp;
   logic [3:0] m_flags, m_fid;
   logic [4:0] m_rd;
   logic [6:0] m_sqn, m_ssqn, m_lsqn;
   logic [2:0] m_foff;

   function automatic void model_reset();
      m_wait = 0; m_run = 0;
      m_valid = 0; m_timeout = 0; m_stall = 0; m_comp = 0;
      m_flags = 0; m_fid = 0; m_rd = 0; m_sqn = 0; m_ssqn = 0; m_lsqn = 0; m_foff = 0;
   endfunction

   function automatic void take_head(logic is_timeout);
      m_valid = 1; m_timeout = is_timeout; m_flags = FLAGS_NX; m_rd = 0;
      m_sqn = IN_headSqN; m_ssqn = IN_headStoreSqN; m_lsqn = IN_headLoadSqN;
      m_fid = IN_headFetchID; m_foff = IN_headFetchOffs; m_comp = IN_headCompressed;
   endfunction

   function automatic void model_step();
      bit stuck, armed;
      if (rst) begin
         model_reset();
         return;
      end
      m_valid = 0; m_timeout = 0;
      stuck = IN_headValid && !IN_commitRetire && !IN_branchTaken;
      armed = stuck && !IN_disableTimeout;
      if (m_wait) begin
         if (IN_branchTaken) m_wait = 0;
         m_run = 0;
      end else if (IN_commitTrap) begin
         m_valid = 1; m_timeout = 0; m_flags = IN_flags; m_rd = IN_rd;
         m_sqn = IN_sqN; m_ssqn = IN_storeSqN; m_lsqn = IN_loadSqN;
         m_fid = IN_fetchID; m_foff = IN_fetchOffs; m_comp = IN_compressed;
         m_wait = 1; m_run = 0;
      end else if (armed && m_run == T - 1) begin
         take_head(1'b1);
         m_wait = 1; m_run = 0;
      end else begin
         if (armed && m_run == T / 2 - 1) take_head(1'b0);
         m_run = stuck ? ((m_run + 1 > T - 1) ? T - 1 : m_run + 1) : 0;
      end
      m_stall = m_wait;
   endfunction

   // Advance one clock: model consumes the driven inputs; returns at the next falling edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      IN_commitTrap = 0; IN_commitRetire = 0; IN_flags = 0; IN_rd = 0;
      IN_sqN = 0; IN_storeSqN = 0; IN_loadSqN = 0; IN_fetchID = 0; IN_fetchOffs = 0;
      IN_compressed = 0; IN_headValid = 0; IN_headSqN = 0; IN_headStoreSqN = 0;
      IN_headLoadSqN = 0; IN_headFetchID = 0; IN_headFetchOffs = 0; IN_headCompressed = 0;
      IN_branchTaken = 0; IN_disableTimeout = 0;
   endtask

   task automatic flush();
      quiet_inputs();
      IN_branchTaken = 1;
      cycle();
      IN_branchTaken = 0;
      cycle();
   endtask

   task automatic test_reset();
      rst = 1;
      quiet_inputs();
      model_reset();
      cycle();
      cycle();
      vec_cnt++;
      if ({OUT_valid, OUT_timeout, OUT_stall} !== 3'b000) begin
         err_cnt++; $display("FAIL reset_ctrl: got %b expected 000", {OUT_valid, OUT_timeout, OUT_stall});
      end
      vec_cnt++;
      if ({OUT_flags, OUT_rd, OUT_sqN, OUT_storeSqN, OUT_loadSqN, OUT_fetchID, OUT_fetchOffs, OUT_compressed} !== '0) begin
         err_cnt++; $display("FAIL reset_data: sqN=%0h flags=%0h rd=%0h expected all zero", OUT_sqN, OUT_flags, OUT_rd);
      end
      rst = 0;
      cycle();
   endtask

   task automatic test_commit_trap();
      quiet_inputs();
      IN_commitTrap = 1; IN_flags = FLAGS_TRAP; IN_rd = 5'd11; IN_sqN = 7'h12;
      IN_storeSqN = 7'h21; IN_loadSqN = 7'h3a; IN_fetchID = 4'h9; IN_fetchOffs = 3'd5; IN_compressed = 1;
      cycle();
      IN_commitTrap = 0;
      vec_cnt++;
      if ({OUT_valid, OUT_timeout, OUT_stall} !== 3'b101) begin
         err_cnt++; $display("FAIL trap_ctrl: got %b expected 101", {OUT_valid, OUT_timeout, OUT_stall});
      end
      vec_cnt++;
      if (OUT_rd !== 5'd11 || OUT_sqN !== 7'h12 || OUT_flags !== FLAGS_TRAP) begin
         err_cnt++; $display("FAIL trap_fields: rd=%0d sqN=%0h flags=%0h expected 11 12 %0h", OUT_rd, OUT_sqN, OUT_flags, FLAGS_TRAP);
      end
      vec_cnt++;
      if ({OUT_storeSqN, OUT_loadSqN, OUT_fetchID, OUT_fetchOffs, OUT_compressed} !== {7'h21, 7'h3a, 4'h9, 3'd5, 1'b1}) begin
         err_cnt++; $display("FAIL trap_loc: ssqn=%0h lsqn=%0h fid=%0h foff=%0d c=%b", OUT_storeSqN, OUT_loadSqN, OUT_fetchID, OUT_fetchOffs, OUT_compressed);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         vec_cnt++;
         if (OUT_valid !== 1'b0 || OUT_stall !== 1'b1 || OUT_sqN !== 7'h12) begin
            err_cnt++; $display("FAIL trap_hold: valid=%b stall=%b sqN=%0h expected 0 1 12", OUT_valid, OUT_stall, OUT_sqN);
         end
      end
      IN_branchTaken = 1;
      cycle();
      IN_branchTaken = 0;
      vec_cnt++;
      if (OUT_stall !== 1'b0) begin
         err_cnt++; $display("FAIL trap_release: stall=%b expected 0", OUT_stall);
      end
   endtask

   task automatic test_back_to_back();
      quiet_inputs();
      IN_commitTrap = 1; IN_sqN = 7'h01;
      cycle();
      IN_commitTrap = 0; IN_branchTaken = 1;
      cycle();
      IN_branchTaken = 0; IN_commitTrap = 1; IN_sqN = 7'h02;
      cycle();
      IN_commitTrap = 0;
      vec_cnt++;
      if (OUT_valid !== 1'b1 || OUT_stall !== 1'b1 || OUT_sqN !== 7'h02) begin
         err_cnt++; $display("FAIL b2b_second: valid=%b stall=%b sqN=%0h expected 1 1 02", OUT_valid, OUT_stall, OUT_sqN);
      end
      flush();
   endtask

   task automatic test_timeout(input int retire_at, input int dbg1, input int dbg2, input int tmo);
      quiet_inputs();
      cycle();
      IN_headValid = 1; IN_headSqN = 7'h05; IN_headFetchID = 4'h3;
      for (int i = 1; i <= tmo; i++) begin
         IN_commitRetire = (i == retire_at + 1);
         cycle();
         vec_cnt++;
         if (i == dbg1 || i == dbg2) begin
            if (OUT_valid !== 1'b1 || OUT_timeout !== 1'b0 || OUT_flags !== FLAGS_NX || OUT_sqN !== 7'h05 || OUT_stall !== 1'b0) begin
               err_cnt++; $display("FAIL debug_uop@%0d: valid=%b tmo=%b flags=%0h sqN=%0h stall=%b", i, OUT_valid, OUT_timeout, OUT_flags, OUT_sqN, OUT_stall);
            end
         end else if (i == tmo) begin
            if (OUT_valid !== 1'b1 || OUT_timeout !== 1'b1 || OUT_flags !== FLAGS_NX || OUT_sqN !== 7'h05 || OUT_stall !== 1'b1 || OUT_rd !== 5'd0) begin
               err_cnt++; $display("FAIL timeout_uop@%0d: valid=%b tmo=%b flags=%0h sqN=%0h stall=%b", i, OUT_valid, OUT_timeout, OUT_flags, OUT_sqN, OUT_stall);
            end
         end else if (OUT_valid !== 1'b0) begin
            err_cnt++; $display("FAIL stray_uop@%0d: valid=%b expected 0", i, OUT_valid);
         end
      end
      flush();
   endtask

   task automatic test_trap_ignored_in_wait();
      quiet_inputs();
      IN_commitTrap = 1; IN_sqN = 7'h44;
      cycle();
      IN_sqN = 7'h55;
      for (int i = 0; i < 3; i++) begin
         cycle();
         vec_cnt++;
         if (OUT_valid !== 1'b0 || OUT_stall !== 1'b1 || OUT_sqN !== 7'h44) begin
            err_cnt++; $display("FAIL wait_ignore: valid=%b stall=%b sqN=%0h expected 0 1 44", OUT_valid, OUT_stall, OUT_sqN);
         end
      end
      flush();
   endtask

   task automatic test_trap_vs_timeout();
      quiet_inputs();
      cycle();
      IN_headValid = 1; IN_headSqN = 7'h05;
      for (int i = 0; i < T - 1; i++) cycle();
      IN_commitTrap = 1; IN_sqN = 7'h33; IN_flags = FLAGS_TRAP;
      cycle();
      IN_commitTrap = 0; IN_headValid = 0;
      vec_cnt++;
      if (OUT_valid !== 1'b1 || OUT_timeout !== 1'b0 || OUT_sqN !== 7'h33 || OUT_flags !== FLAGS_TRAP) begin
         err_cnt++; $display("FAIL trap_priority: valid=%b tmo=%b sqN=%0h flags=%0h expected 1 0 33 %0h", OUT_valid, OUT_timeout, OUT_sqN, OUT_flags, FLAGS_TRAP);
      end
      cycle();
      vec_cnt++;
      if (OUT_valid !== 1'b0) begin
         err_cnt++; $display("FAIL trap_priority_single: valid=%b expected 0", OUT_valid);
      end
      flush();
   endtask

   task automatic test_async_reset();
      quiet_inputs();
      IN_commitTrap = 1; IN_sqN = 7'h6c;
      cycle();
      IN_commitTrap = 0;
      #2 rst = 1;
      #1;
      vec_cnt++;
      if (OUT_valid !== 1'b0 || OUT_stall !== 1'b0 || OUT_sqN !== 7'h00) begin
         err_cnt++; $display("FAIL async_reset: valid=%b stall=%b sqN=%0h expected 0 0 00", OUT_valid, OUT_stall, OUT_sqN);
      end
      #1 rst = 0;
      model_reset();
      @(negedge clk);
      // Fresh IDLE with zero count: debug uop exactly T/2 cycles into a stall.
      IN_headValid = 1; IN_headSqN = 7'h0e;
      for (int i = 1; i <= T / 2; i++) begin
         cycle();
         vec_cnt++;
         if (OUT_valid !== (i == T / 2) || OUT_stall !== 1'b0) begin
            err_cnt++; $display("FAIL post_reset@%0d: valid=%b stall=%b expected %b 0", i, OUT_valid, OUT_stall, (i == T / 2));
         end
      end
      flush();
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         IN_headValid      = ($urandom % 16) != 0;
         IN_commitRetire   = ($urandom % 25) == 0;
         IN_commitTrap     = ($urandom % 30) == 0;
         IN_branchTaken    = m_wait ? (($urandom % 4) == 0) : (($urandom % 60) == 0);
         IN_disableTimeout = ((i / 300) % 3) == 2;
         IN_flags = 4'($urandom); IN_rd = 5'($urandom);
         IN_sqN = 7'($urandom); IN_storeSqN = 7'($urandom); IN_loadSqN = 7'($urandom);
         IN_fetchID = 4'($urandom); IN_fetchOffs = 3'($urandom); IN_compressed = 1'($urandom);
         IN_headSqN = 7'($urandom); IN_headStoreSqN = 7'($urandom); IN_headLoadSqN = 7'($urandom);
         IN_headFetchID = 4'($urandom); IN_headFetchOffs = 3'($urandom); IN_headCompressed = 1'($urandom);
         cycle();
         vec_cnt++;
         if ({OUT_valid, OUT_timeout, OUT_stall} !== {m_valid, m_timeout, m_stall}) begin
            err_cnt++; $display("FAIL rand_ctrl@%0d: got vts=%b expected %b", i, {OUT_valid, OUT_timeout, OUT_stall}, {m_valid, m_timeout, m_stall});
         end
         vec_cnt++;
         if ({OUT_flags, OUT_rd, OUT_sqN, OUT_storeSqN, OUT_loadSqN, OUT_fetchID, OUT_fetchOffs, OUT_compressed}
             !== {m_flags, m_rd, m_sqn, m_ssqn, m_lsqn, m_fid, m_foff, m_comp}) begin
            err_cnt++; $display("FAIL rand_data@%0d: got %h expected %h", i,
               {OUT_flags, OUT_rd, OUT_sqN, OUT_storeSqN, OUT_loadSqN, OUT_fetchID, OUT_fetchOffs, OUT_compressed},
               {m_flags, m_rd, m_sqn, m_ssqn, m_lsqn, m_fid, m_foff, m_comp});
         end
      end
      flush();
   endtask

   initial begin
      test_reset();
      test_commit_trap();
      test_back_to_back();
      test_timeout(-10, T / 2, -1, T);
      test_timeout(10, T / 2, 11 + T / 2, 11 + T);
      test_trap_ignored_in_wait();
      test_trap_vs_timeout();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
